calc_window_sums: RTL
=====================

CALC_WINDOW_SUMS -- requirements
Module: calc_window_sums

Interface
REQ-001 SHALL have parameter: WIN_LOG2, 8, log2 of samples per window (window N = 2^WIN_LOG2 = 256).
REQ-002 SHALL have parameter: PIX_W, 8, unsigned pixel width.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: clear  input  1  synchronous abort; discards the current partial window.
REQ-006 SHALL have port: in_valid  input  1  pixel pair f/g present.
REQ-007 SHALL have port: in_ready  output  1  block can accept a pair.
REQ-008 SHALL have port: f_pix  input  PIX_W  left-image pixel, unsigned.
REQ-009 SHALL have port: g_pix  input  PIX_W  right-image pixel, unsigned.
REQ-010 SHALL have port: out_valid  output  1  window sums valid.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts sums.
REQ-012 SHALL have ports: fsum, f2sum, gsum, g2sum, fgsum  output  32 each  unsigned window sums of f, f*f, g, g*g, f*g.

Function
REQ-013 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL accept a pair only on a cycle where in_valid=1 and in_ready=1.
REQ-015 On each accepted pair, SHALL add f, f*f, g, g*g and f*g to the five accumulators and increment the sample counter.
REQ-016 SHALL zero-extend all products and sums to 32 bits; for the default parameters no overflow is possible (max f2sum = 16 646 400).
REQ-017 When the accepted pair is the N-th of the window, SHALL load the final sums (including that pair) into the output registers and enter HOLD in the next cycle.
REQ-018 Latency SHALL be one cycle: out_valid rises in the cycle after the N-th accept.
REQ-019 In HOLD, SHALL keep the output registers and out_valid stable until out_valid=1 and out_ready=1 in the same cycle.
REQ-020 On that output handshake, SHALL zero the accumulators and counter and return to ACCUM, with in_ready=1 in the next cycle.
REQ-021 No pair SHALL be accepted in the cycle of the output handshake (in_ready is 0 in HOLD).
REQ-022 clear=1 in ACCUM SHALL zero the accumulators and counter; any pair presented in that cycle SHALL be discarded, not accumulated.
REQ-023 clear=1 in HOLD SHALL drop out_valid, zero the accumulators, counter and output registers, and return to ACCUM.
REQ-024 If clear=1 coincides with an output handshake, clear SHALL take precedence, with the same end state as REQ-023.
REQ-025 If clear=1 coincides with the N-th accept, the window SHALL be discarded and out_valid SHALL NOT assert.
REQ-026 The counter SHALL be WIN_LOG2+1 bits wide and SHALL never wrap inside a window.
REQ-027 Outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-028 Output sums SHALL directly satisfy the downstream ZSSD formula, which uses shift-by-WIN_LOG2 scaling, so N SHALL equal 2^WIN_LOG2.

Reset
REQ-029 rst_n=0 SHALL immediately, and asynchronously to clk, force state ACCUM, counter 0, all accumulators 0, and all five sum outputs 0.
REQ-030 During reset, out_valid SHALL be 0 and in_ready SHALL be 0.
REQ-031 in_ready SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-window or in HOLD SHALL lose all partial and held data without any spurious out_valid.

Verification
REQ-033 SHALL test: 256 pairs of f=1, g=1 with continuous valid -> one cycle later out_valid=1; fsum=gsum=f2sum=g2sum=fgsum=256.
REQ-034 SHALL test: 256 pairs of f=255, g=255 -> fsum=gsum=65280; f2sum=g2sum=fgsum=16646400.
REQ-035 SHALL test: f=i (i=0..255), g=0, with random in_valid gaps -> fsum=32640, f2sum=5559680, gsum=g2sum=fgsum=0; out_valid timing is the cycle after the last accept.
REQ-036 SHALL test: out_ready held low 10 cycles after out_valid -> outputs stable, in_ready=0, no pair accepted; after the handshake, the next window starts from zero.
REQ-037 SHALL test: clear after 100 pairs, then 256 pairs f=2, g=3 -> fsum=512, gsum=768, f2sum=1024, g2sum=2304, fgsum=1536.
REQ-038 SHALL test: rst_n pulsed low asynchronously, between clock edges, mid-window and in HOLD -> outputs 0 immediately; the next full window produces correct sums.

Source files
------------

// File: rtl/calc_window_sums.sv
`default_nettype none
// ============================================================================
//  Module   : calc_window_sums
//  Purpose  : Accumulates the five window statistics used by a ZSSD matcher
//             (sum f, sum f*f, sum g, sum g*g, sum f*g) over windows of
//             N = 2^WIN_LOG2 pixel pairs, then holds the result until the
//             consumer takes it.
//  Ports    : clk, rst_n (async, active low), clear (sync abort)
//             in_valid/in_ready, f_pix, g_pix     -- pixel pair input
//             out_valid/out_ready                 -- result handshake
//             fsum, f2sum, gsum, g2sum, fgsum     -- registered window sums
//  Revision : 1.0 - initial release
// ============================================================================
module calc_window_sums #(
    parameter int WIN_LOG2 = 8,
    parameter int PIX_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] f_pix,
    input  logic [PIX_W-1:0] g_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      fsum,
    output logic [31:0]      f2sum,
    output logic [31:0]      gsum,
    output logic [31:0]      g2sum,
    output logic [31:0]      fgsum
);

    // Counter index of the last pair of a window (N-1).
    localparam logic [WIN_LOG2:0] c_LAST_IDX = {1'b0, {WIN_LOG2{1'b1}}};
    localparam logic [WIN_LOG2:0] c_ONE      = {{WIN_LOG2{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_in_ready, r_out_valid;
    logic [WIN_LOG2:0] r_count, w_count_nxt;

    logic [31:0] r_acc_f,  r_acc_f2,  r_acc_g,  r_acc_g2,  r_acc_fg;
    logic [31:0] w_acc_f,  w_acc_f2,  w_acc_g,  w_acc_g2,  w_acc_fg;
    logic [31:0] r_sum_f,  r_sum_f2,  r_sum_g,  r_sum_g2,  r_sum_fg;
    logic [31:0] w_sum_f,  w_sum_f2,  w_sum_g,  w_sum_g2,  w_sum_fg;

    logic [31:0] w_add_f, w_add_f2, w_add_g, w_add_g2, w_add_fg;
    logic        w_accept;

    // in_ready is a register, so it is only ever high in ACCUM.
    assign w_accept = in_valid & r_in_ready;

    // Products are formed at full 32-bit width; no overflow for default sizes.
    assign w_add_f  = r_acc_f  + 32'(f_pix);
    assign w_add_f2 = r_acc_f2 + 32'(f_pix) * 32'(f_pix);
    assign w_add_g  = r_acc_g  + 32'(g_pix);
    assign w_add_g2 = r_acc_g2 + 32'(g_pix) * 32'(g_pix);
    assign w_add_fg = r_acc_fg + 32'(f_pix) * 32'(g_pix);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_acc_f     = r_acc_f;
        w_acc_f2    = r_acc_f2;
        w_acc_g     = r_acc_g;
        w_acc_g2    = r_acc_g2;
        w_acc_fg    = r_acc_fg;
        w_sum_f     = r_sum_f;
        w_sum_f2    = r_sum_f2;
        w_sum_g     = r_sum_g;
        w_sum_g2    = r_sum_g2;
        w_sum_fg    = r_sum_fg;

        case (r_state)
            ACCUM: begin
                if (clear) begin
                    // Abort: the pair offered this cycle is dropped too.
                    w_count_nxt = '0;
                    w_acc_f     = '0;
                    w_acc_f2    = '0;
                    w_acc_g     = '0;
                    w_acc_g2    = '0;
                    w_acc_fg    = '0;
                end else if (w_accept) begin
                    w_count_nxt = r_count + c_ONE;
                    w_acc_f     = w_add_f;
                    w_acc_f2    = w_add_f2;
                    w_acc_g     = w_add_g;
                    w_acc_g2    = w_add_g2;
                    w_acc_fg    = w_add_fg;
                    if (r_count == c_LAST_IDX) begin
                        // Output registers take the sums including this pair.
                        w_sum_f     = w_add_f;
                        w_sum_f2    = w_add_f2;
                        w_sum_g     = w_add_g;
                        w_sum_g2    = w_add_g2;
                        w_sum_fg    = w_add_fg;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (clear || out_ready) begin
                    w_state_nxt = ACCUM;
                    w_count_nxt = '0;
                    w_acc_f     = '0;
                    w_acc_f2    = '0;
                    w_acc_g     = '0;
                    w_acc_g2    = '0;
                    w_acc_fg    = '0;
                end
                // clear beats a simultaneous handshake and also wipes results.
                if (clear) begin
                    w_sum_f  = '0;
                    w_sum_f2 = '0;
                    w_sum_g  = '0;
                    w_sum_g2 = '0;
                    w_sum_fg = '0;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_acc_f     <= '0;
            r_acc_f2    <= '0;
            r_acc_g     <= '0;
            r_acc_g2    <= '0;
            r_acc_fg    <= '0;
            r_sum_f     <= '0;
            r_sum_f2    <= '0;
            r_sum_g     <= '0;
            r_sum_g2    <= '0;
            r_sum_fg    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            // Handshake flags follow the next state so they stay registered.
            r_in_ready  <= (w_state_nxt == ACCUM);
            r_out_valid <= (w_state_nxt == HOLD);
            r_count     <= w_count_nxt;
            r_acc_f     <= w_acc_f;
            r_acc_f2    <= w_acc_f2;
            r_acc_g     <= w_acc_g;
            r_acc_g2    <= w_acc_g2;
            r_acc_fg    <= w_acc_fg;
            r_sum_f     <= w_sum_f;
            r_sum_f2    <= w_sum_f2;
            r_sum_g     <= w_sum_g;
            r_sum_g2    <= w_sum_g2;
            r_sum_fg    <= w_sum_fg;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign fsum      = r_sum_f;
    assign f2sum     = r_sum_f2;
    assign gsum      = r_sum_g;
    assign g2sum     = r_sum_g2;
    assign fgsum     = r_sum_fg;

endmodule
`default_nettype wire
